// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with a sign-fix pass.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Operand_A,
  input  logic [WIDTH-1:0] Operand_B,
  input  logic             Hi_Write,
  input  logic             Lo_Write,
  input  logic [WIDTH-1:0] Write_Data,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 dbz_flag_q, dbz_flag_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic                 busy;
  logic                 load_en;
  logic                 calc_en;
  logic                 fix_en;
  logic                 commit_en;
  logic                 idle_wr_en;

  logic                 a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     acc_hi, acc_lo;

  // Op[0] set means unsigned; only signed ops take absolute values.
  assign a_neg  = Operand_A[WIDTH-1] & ~Op[0];
  assign b_neg  = Operand_B[WIDTH-1] & ~Op[0];
  assign a_abs  = a_neg ? (~Operand_A) + WIDTH'(1) : Operand_A;
  assign b_abs  = b_neg ? (~Operand_B) + WIDTH'(1) : Operand_B;
  assign b_zero = (Operand_B == '0);

  assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
  assign acc_lo = acc_q[WIDTH-1:0];

  // Multiply: upper half accumulates, multiplier shifts out of the low end.
  assign mul_sum  = {1'b0, acc_hi} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_lo[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, low half shifts dividend out / quotient in.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = (Op[1] && b_zero) ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (state_q != StIdle);
    load_en    = (state_q == StIdle) && Start;
    idle_wr_en = (state_q == StIdle) && !Start;
    calc_en    = (state_q == StCalc);
    fix_en     = (state_q == StFix);
    commit_en  = (state_q == StDone);
  end

  // Datapath next-state
  always_comb begin
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dbz_flag_d = dbz_flag_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;

    if (load_en) begin
      is_div_d   = Op[1];
      neg_res_d  = a_neg ^ b_neg;
      neg_rem_d  = a_neg;
      dbz_flag_d = Op[1] & b_zero;
      cnt_d      = '0;
      if (Op[1]) begin
        opnd_d = b_abs;
        acc_d  = {{WIDTH{1'b0}}, a_abs};
      end else begin
        opnd_d = a_abs;
        acc_d  = {{WIDTH{1'b0}}, b_abs};
      end
    end else if (calc_en) begin
      cnt_d = cnt_q + CNT_W'(1);
      acc_d = is_div_q ? div_next : mul_next;
    end else if (fix_en) begin
      if (is_div_q) begin
        // Quotient sign follows the operand signs, remainder follows the dividend.
        acc_d = {neg_rem_q ? (~acc_hi) + WIDTH'(1) : acc_hi,
                 neg_res_q ? (~acc_lo) + WIDTH'(1) : acc_lo};
      end else if (neg_res_q) begin
        acc_d = (~acc_q) + (2*WIDTH)'(1);
      end
    end
  end

  // Architectural registers and status pulses
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = commit_en;
    dbz_d  = commit_en & dbz_flag_q;

    if (idle_wr_en) begin
      if (Hi_Write) hi_d = Write_Data;
      if (Lo_Write) lo_d = Write_Data;
    end

    if (commit_en && !dbz_flag_q) begin
      hi_d = acc_hi;
      lo_d = acc_lo;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_flag_q <= 1'b0;
      cnt_q      <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dbz_flag_q <= dbz_flag_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign Busy        = busy;
  assign Done        = done_q;
  assign Div_By_Zero = dbz_q;
  assign Hi          = hi_q;
  assign Lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit: arithmetic vectors, divide by zero,
// MTHI/MTLO, start-while-busy and mid-operation reset.
module tb_mult_div_unit;

  localparam int unsigned WIDTH = 32;
  localparam int          LAT   = WIDTH + 2;

  logic             Clock;
  logic             Reset;
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] Operand_A;
  logic [WIDTH-1:0] Operand_B;
  logic             Hi_Write;
  logic             Lo_Write;
  logic [WIDTH-1:0] Write_Data;
  logic             Busy;
  logic             Done;
  logic             Div_By_Zero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  mult_div_unit #(
    .WIDTH(WIDTH),
    .CNT_W(5)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Op         (Op),
    .Operand_A  (Operand_A),
    .Operand_B  (Operand_B),
    .Hi_Write   (Hi_Write),
    .Lo_Write   (Lo_Write),
    .Write_Data (Write_Data),
    .Busy       (Busy),
    .Done       (Done),
    .Div_By_Zero(Div_By_Zero),
    .Hi         (Hi),
    .Lo         (Lo)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    vec_t v;
    v.name = name;
    v.op   = op;
    v.a    = a;
    v.b    = b;
    v.hi   = hi;
    v.lo   = lo;
    vecs.push_back(v);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz, input int exp_lat);
    int cyc;
    int busy_cnt;
    Op        = op;
    Operand_A = a;
    Operand_B = b;
    Start     = 1'b1;
    tick();
    Start     = 1'b0;
    // Operands must no longer matter once Start has been taken.
    Operand_A = 32'h5A5A_0F0F;
    Operand_B = 32'h0000_0000;
    cyc       = 0;
    busy_cnt  = 0;
    while (!Done && cyc < 200) begin
      if (Busy) busy_cnt++;
      tick();
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'(exp_lat));
    check({name, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check({name, " busy at done"}, 64'(Busy), 64'(0));
    check({name, " hi"}, 64'(Hi), 64'(exp_hi));
    check({name, " lo"}, 64'(Lo), 64'(exp_lo));
    check({name, " dbz"}, 64'(Div_By_Zero), 64'(exp_dbz));
    tick();
    check({name, " done one cycle"}, 64'(Done), 64'(0));
  endtask

  task automatic mt_write(input logic wr_hi, input logic wr_lo, input logic [31:0] data);
    Hi_Write   = wr_hi;
    Lo_Write   = wr_lo;
    Write_Data = data;
    tick();
    Hi_Write   = 1'b0;
    Lo_Write   = 1'b0;
  endtask

  initial begin
    int cyc;
    int done_cnt;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;

    checks     = 0;
    errors     = 0;
    Reset      = 1'b1;
    Start      = 1'b0;
    Op         = 2'b00;
    Operand_A  = '0;
    Operand_B  = '0;
    Hi_Write   = 1'b0;
    Lo_Write   = 1'b0;
    Write_Data = '0;

    add_vec("multu max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    add_vec("mult -3x5",     2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    add_vec("div -7/2",      2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    add_vec("divu 7/2",      2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);
    add_vec("div minint/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    add_vec("mult 7x-1",     2'b00, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    add_vec("div 7/-2",      2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    add_vec("multu 2^16sq",  2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
    add_vec("divu max/1",    2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF);
    add_vec("mult minint^2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    add_vec("div -8/-3",     2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002);

    repeat (3) tick();
    check("reset busy", 64'(Busy), 64'(0));
    check("reset done", 64'(Done), 64'(0));
    check("reset dbz", 64'(Div_By_Zero), 64'(0));
    check("reset hi", 64'(Hi), 64'(0));
    check("reset lo", 64'(Lo), 64'(0));
    Reset = 1'b0;
    tick();

    mt_write(1'b1, 1'b0, 32'hAAAA_5555);
    check("mthi hi", 64'(Hi), 64'h0000_0000_AAAA_5555);
    check("mthi lo untouched", 64'(Lo), 64'(0));
    mt_write(1'b0, 1'b1, 32'h1234_5678);
    check("mtlo lo", 64'(Lo), 64'h0000_0000_1234_5678);
    check("mtlo hi untouched", 64'(Hi), 64'h0000_0000_AAAA_5555);

    run_op("divu by zero", 2'b11, 32'h0000_0007, 32'h0, 32'hAAAA_5555, 32'h1234_5678, 1'b1, 1);
    run_op("div by zero", 2'b10, 32'hFFFF_FFFB, 32'h0, 32'hAAAA_5555, 32'h1234_5678, 1'b1, 1);

    mt_write(1'b1, 1'b1, 32'h0F0F_F0F0);
    check("mthi+mtlo hi", 64'(Hi), 64'h0000_0000_0F0F_F0F0);
    check("mthi+mtlo lo", 64'(Lo), 64'h0000_0000_0F0F_F0F0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0, LAT);
    end

    // Start with a simultaneous MTHI, then a second Start plus MTHI/MTLO while busy.
    pre_hi     = vecs[vecs.size()-1].hi;
    pre_lo     = vecs[vecs.size()-1].lo;
    Op         = 2'b01;
    Operand_A  = 32'd3;
    Operand_B  = 32'd4;
    Hi_Write   = 1'b1;
    Write_Data = 32'h0000_0777;
    Start      = 1'b1;
    tick();
    Start      = 1'b0;
    Hi_Write   = 1'b0;
    check("start beats mthi", 64'(Hi), 64'(pre_hi));
    cyc = 0;
    repeat (4) begin
      tick();
      cyc++;
    end
    Start      = 1'b1;
    Op         = 2'b10;
    Operand_A  = 32'd100;
    Operand_B  = 32'd7;
    Hi_Write   = 1'b1;
    Lo_Write   = 1'b1;
    Write_Data = 32'hDEAD_BEEF;
    tick();
    cyc++;
    Start      = 1'b0;
    Hi_Write   = 1'b0;
    Lo_Write   = 1'b0;
    check("busy mthi ignored", 64'(Hi), 64'(pre_hi));
    check("busy mtlo ignored", 64'(Lo), 64'(pre_lo));
    while (!Done && cyc < 200) begin
      tick();
      cyc++;
    end
    check("busy seq latency", 64'(cyc), 64'(LAT));
    check("busy seq hi", 64'(Hi), 64'(0));
    check("busy seq lo", 64'(Lo), 64'd12);
    tick();
    check("busy seq no relaunch", 64'(Busy), 64'(0));

    // Reset in the middle of an operation.
    mt_write(1'b1, 1'b0, 32'hCAFE_0001);
    Op        = 2'b00;
    Operand_A = 32'hFFFF_FFFD;
    Operand_B = 32'd5;
    Start     = 1'b1;
    tick();
    Start     = 1'b0;
    repeat (9) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midop reset busy", 64'(Busy), 64'(0));
    check("midop reset hi", 64'(Hi), 64'(0));
    check("midop reset lo", 64'(Lo), 64'(0));
    check("midop reset done", 64'(Done), 64'(0));
    done_cnt = 0;
    repeat (40) begin
      tick();
      if (Done) done_cnt++;
    end
    check("no done after reset", 64'(done_cnt), 64'(0));
    run_op("mult after reset", 2'b00, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
